// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM controller: mode and breathe-direction
// encodings, register field positions and the register address map.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 16;
    localparam int MODE_HI = 15;
    localparam int MODE_LO = 14;

    // Channel registers occupy 0..channels-1; the prescaler sits right after them.
    function automatic logic [ADDR_W-1:0] presc_addr(input int channels);
        return ADDR_W'(channels);
    endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Register write port from the CPU I/O decode into the LED PWM controller.
interface led_pwm_ctrl_if;
    import led_pwm_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active duty and mode, breathe ramp and the registered
// PWM compare that drives the pad.
//
//   state    | meaning
//   DIR_UP   | breathe level climbs by one per frame until it reaches duty
//   DIR_DOWN | breathe level falls by one per frame until it reaches zero
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int DUTY_W     = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DUTY_W-1:0] wr_duty,
    input  mode_e             wr_mode,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic              frame_end,
    input  logic              blink_on,
    output logic              enter_blink,
    output logic              led
);

    localparam logic LED_INACTIVE = (ACTIVE_LOW != 0);

    logic [DUTY_W-1:0] shadow_duty_q, shadow_duty_d;
    mode_e             shadow_mode_q, shadow_mode_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    mode_e             mode_q, mode_d;
    logic [DUTY_W-1:0] level_q, level_d;
    dir_e              dir_q, dir_d;
    logic              led_q, led_d;

    logic              step_up;
    logic [DUTY_W-1:0] level_step;
    logic [DUTY_W-1:0] eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_duty_q <= '0;
            shadow_mode_q <= MODE_OFF;
            duty_q        <= '0;
            mode_q        <= MODE_OFF;
            level_q       <= '0;
            dir_q         <= DIR_UP;
            led_q         <= LED_INACTIVE;
        end else begin
            shadow_duty_q <= shadow_duty_d;
            shadow_mode_q <= shadow_mode_d;
            duty_q        <= duty_d;
            mode_q        <= mode_d;
            level_q       <= level_d;
            dir_q         <= dir_d;
            led_q         <= led_d;
        end
    end

    // Copying from the post-write shadow lets a write coinciding with frame_end land in active.
    always_comb begin
        shadow_duty_d = shadow_duty_q;
        shadow_mode_d = shadow_mode_q;
        duty_d        = duty_q;
        mode_d        = mode_q;
        if (wr_en) begin
            shadow_duty_d = wr_duty;
            shadow_mode_d = wr_mode;
        end
        if (frame_end) begin
            duty_d = shadow_duty_d;
            mode_d = shadow_mode_d;
        end
    end

    assign enter_blink = frame_end && (mode_d == MODE_BLINK) && (mode_q != MODE_BLINK);

    always_comb begin
        level_d    = level_q;
        dir_d      = dir_q;
        step_up    = (dir_q == DIR_UP) ? (level_q < duty_d) : (level_q == '0);
        level_step = step_up ? level_q + DUTY_W'(1) : level_q - DUTY_W'(1);
        if (frame_end && (mode_d == MODE_BREATHE)) begin
            if ((mode_q != MODE_BREATHE) || (duty_d == '0)) begin
                level_d = '0;
                dir_d   = DIR_UP;
            end else if (level_q > duty_d) begin
                level_d = duty_d;
                dir_d   = DIR_DOWN;
            end else begin
                level_d = level_step;
                if (step_up) begin
                    dir_d = (level_step == duty_d) ? DIR_DOWN : DIR_UP;
                end else begin
                    dir_d = (level_step == '0) ? DIR_UP : DIR_DOWN;
                end
            end
        end
    end

    always_comb begin
        eff = '0;
        case (mode_q)
            MODE_STATIC:  eff = duty_q;
            MODE_BLINK:   eff = blink_on ? duty_q : '0;
            MODE_BREATHE: eff = level_q;
            default:      eff = '0;
        endcase
        led_d = (pwm_cnt < eff) ? ~LED_INACTIVE : LED_INACTIVE;
    end

    assign led = led_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped PWM controller for the board status LEDs: prescaler, frame
// counter, shared blink phase and register write decode around N channels.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int DUTY_W       = 8,
    parameter int PRESC_W      = 16,
    parameter int PRESC_RST    = 0,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                clk,
    input  logic                rst,
    led_pwm_ctrl_if.slave       bus,
    output logic [CHANNELS-1:0] led_out,
    output logic                frame_tick
);

    localparam int                BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [ADDR_W-1:0]  PRESC_ADDR = presc_addr(CHANNELS);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic               frame_tick_q, frame_tick_d;

    logic                tick;
    logic                frame_end;
    logic                presc_wr;
    logic [CHANNELS-1:0] ch_wr;
    logic [CHANNELS-1:0] enter_blink;
    logic [DUTY_W-1:0]   wr_duty;
    mode_e               wr_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= PRESC_W'(PRESC_RST);
            presc_cnt_q  <= '0;
            pwm_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            presc_cnt_q  <= presc_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign wr_duty  = bus.wr_data[DUTY_W-1:0];
    assign wr_mode  = mode_e'(bus.wr_data[MODE_HI:MODE_LO]);
    assign presc_wr = bus.wr_en && (bus.wr_addr == PRESC_ADDR);

    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ch_wr[i] = bus.wr_en && (bus.wr_addr == ADDR_W'(i));
        end
    end

    // A prescaler write restarts the frame, so the aborted frame never reports an end.
    always_comb begin
        tick         = (presc_cnt_q == presc_q);
        frame_end    = tick && (&pwm_cnt_q) && !presc_wr;
        presc_d      = presc_q;
        presc_cnt_d  = tick ? '0 : presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d    = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
        if (presc_wr) begin
            presc_d     = bus.wr_data[PRESC_W-1:0];
            presc_cnt_d = '0;
            pwm_cnt_d   = '0;
        end
        frame_tick_d = frame_end;
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_end) begin
            if (|enter_blink) begin
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        led_pwm_channel #(
            .DUTY_W     (DUTY_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (ch_wr[g]),
            .wr_duty     (wr_duty),
            .wr_mode     (wr_mode),
            .pwm_cnt     (pwm_cnt_q),
            .frame_end   (frame_end),
            .blink_on    (blink_on_q),
            .enter_blink (enter_blink[g]),
            .led         (led_out[g])
        );
    end

    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: frame-level reference model of shadow/active registers,
// blink phase and breathe ramp; compares per-frame on-time and frame_tick timing.
module tb_led_pwm_ctrl;
    import led_pwm_pkg::*;

    localparam int CH    = 3;
    localparam int BF    = 2;
    localparam int FRAME = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] led_out;
    logic          frame_tick;

    led_pwm_ctrl_if u_bus ();

    led_pwm_ctrl #(
        .CHANNELS     (CH),
        .DUTY_W       (8),
        .PRESC_W      (16),
        .PRESC_RST    (0),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (u_bus),
        .led_out    (led_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model state
    int m_presc;
    int m_k;
    int sh_duty[CH], sh_mode[CH], act_duty[CH], act_mode[CH], lvl[CH];
    bit up_dir[CH];
    int bl_cnt;
    bit bl_on;
    int acc_low[CH];
    int stray;
    int frames_done = 0;

    function automatic int eff_of(input int c);
        case (act_mode[c])
            1:       return act_duty[c];
            2:       return bl_on ? act_duty[c] : 0;
            3:       return lvl[c];
            default: return 0;
        endcase
    endfunction

    task automatic clear_acc();
        for (int c = 0; c < CH; c++) acc_low[c] = 0;
        stray = 0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            sh_duty[c] = 0; sh_mode[c] = 0; act_duty[c] = 0; act_mode[c] = 0;
            lvl[c] = 0; up_dir[c] = 1'b1;
        end
        bl_cnt = 0; bl_on = 1'b1; m_presc = 0; m_k = 0;
        clear_acc();
    endtask

    task automatic model_frame_end();
        bit entered = 1'b0;
        for (int c = 0; c < CH; c++) begin
            int old_mode = act_mode[c];
            act_duty[c] = sh_duty[c];
            act_mode[c] = sh_mode[c];
            if (act_mode[c] == 2 && old_mode != 2) entered = 1'b1;
            if (act_mode[c] == 3) begin
                if (old_mode != 3 || act_duty[c] == 0) begin
                    lvl[c] = 0; up_dir[c] = 1'b1;
                end else if (lvl[c] > act_duty[c]) begin
                    lvl[c] = act_duty[c]; up_dir[c] = 1'b0;
                end else begin
                    if (up_dir[c] && lvl[c] >= act_duty[c]) up_dir[c] = 1'b0;
                    else if (!up_dir[c] && lvl[c] == 0) up_dir[c] = 1'b1;
                    lvl[c] = up_dir[c] ? lvl[c] + 1 : lvl[c] - 1;
                    if (up_dir[c] && lvl[c] == act_duty[c]) up_dir[c] = 1'b0;
                    else if (!up_dir[c] && lvl[c] == 0) up_dir[c] = 1'b1;
                end
            end
        end
        if (entered) begin
            bl_cnt = 0; bl_on = 1'b1;
        end else begin
            bl_cnt++;
            if (bl_cnt == BF) begin
                bl_cnt = 0; bl_on = !bl_on;
            end
        end
        frames_done++;
    endtask

    // One clock edge: sample outputs after the edge, then advance the model.
    task automatic step();
        int len;
        int a;
        @(posedge clk);
        #1;
        if (rst) begin
            chk_eq("rst_led_out", int'(led_out), (1 << CH) - 1);
            chk_eq("rst_frame_tick", int'(frame_tick), 0);
            model_reset();
            return;
        end
        len = FRAME * (m_presc + 1);
        for (int c = 0; c < CH; c++) if (led_out[c] == 1'b0) acc_low[c]++;
        a = int'(u_bus.wr_addr);
        if (u_bus.wr_en && a == CH) begin
            chk_eq("frame_tick_abort", int'(frame_tick), 0);
            m_presc = int'(u_bus.wr_data);
            m_k = 0;
            clear_acc();
            return;
        end
        if (u_bus.wr_en && a < CH) begin
            sh_duty[a] = int'(u_bus.wr_data[7:0]);
            sh_mode[a] = int'(u_bus.wr_data[15:14]);
        end
        if (m_k == len - 1) begin
            chk_eq("frame_tick", int'(frame_tick), 1);
            chk_eq("stray_frame_tick", stray, 0);
            for (int c = 0; c < CH; c++) begin
                chk_eq($sformatf("ch%0d_on_cycles", c), acc_low[c], eff_of(c) * (m_presc + 1));
            end
            model_frame_end();
            m_k = 0;
            clear_acc();
        end else begin
            if (frame_tick) stray++;
            m_k++;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        u_bus.wr_en   = 1'b1;
        u_bus.wr_addr = a;
        u_bus.wr_data = d;
        step();
        u_bus.wr_en   = 1'b0;
    endtask

    task automatic run_frames(input int n);
        int target = frames_done + n;
        int budget = n * 4200 + 100;
        while (frames_done < target && budget > 0) begin
            step();
            budget--;
        end
        if (frames_done < target) chk_eq("run_frames_timeout", frames_done, target);
    endtask

    task automatic run_until_k(input int k);
        int budget = 5000;
        while (m_k != k && budget > 0) begin
            step();
            budget--;
        end
        if (m_k != k) chk_eq("run_until_k_timeout", m_k, k);
    endtask

    initial begin
        int budget;
        rst           = 1'b1;
        u_bus.wr_en   = 1'b0;
        u_bus.wr_addr = '0;
        u_bus.wr_data = '0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        run_frames(2);
        bus_write(4'(CH), 16'h0000);
        run_frames(1);

        bus_write(4'd0, 16'h4040);
        run_frames(3);

        bus_write(4'd1, 16'h4000);
        run_frames(2);
        bus_write(4'd1, 16'h40FF);
        run_frames(2);
        run_until_k(10);
        bus_write(4'd1, 16'h4080);
        run_frames(2);

        bus_write(4'd2, 16'hC004);
        run_frames(11);
        budget = 20000;
        while (!(lvl[2] == 4 && !up_dir[2]) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) chk_eq("breathe_peak_timeout", lvl[2], 4);
        bus_write(4'd2, 16'hC002);
        run_frames(4);

        bus_write(4'd0, 16'h8064);
        run_frames(7);
        run_until_k(FRAME - 1);
        bus_write(4'd1, 16'h4032);
        run_frames(2);

        run_until_k(100);
        bus_write(4'(CH), 16'd3);
        run_frames(2);
        bus_write(4'(CH), 16'd0);

        bus_write(4'd0, 16'h40C8);
        bus_write(4'd1, 16'h40C8);
        bus_write(4'd2, 16'h40C8);
        run_frames(2);
        run_until_k(77);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        run_frames(2);

        for (int it = 0; it < 60; it++) begin
            int r;
            int gap = $urandom_range(0, 300);
            repeat (gap) step();
            r = $urandom_range(0, 19);
            if (r == 0) begin
                bus_write(4'(CH), 16'($urandom_range(0, 1)));
            end else if (r < 3) begin
                bus_write(4'($urandom_range(CH + 1, 15)), 16'($urandom));
            end else begin
                int duty = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : $urandom_range(0, 255);
                bus_write(4'($urandom_range(0, CH - 1)),
                          {2'($urandom_range(0, 3)), 6'($urandom), 8'(duty)});
            end
        end
        run_frames(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
